// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer for a FIFO in its read clock domain. Pops DATAWIDTH-bit
// entries and packs RATIO consecutive entries into one wide word, presented
// on a valid/ready port. The first popped entry lands in lane 0 (LSBs). A flush
// request emits any partially packed word with a lane mask and m_last set.
//
// Ports
//   rd_clk     in   FIFO read clock; clocks all state
//   rst        in   asynchronous reset, active-low
//   f_empty    in   FIFO empty flag; pops only while low
//   fifo_data  in   FIFO read data, valid the cycle after a pop
//   rd_en      out  pop request to the FIFO
//   flush      in   one-cycle request to emit a partial word
//   m_valid    out  output word valid
//   m_ready    in   downstream accept
//   m_data     out  packed word, lane i = [i*DATAWIDTH +: DATAWIDTH]
//   m_keep     out  lane-valid mask, contiguous from lane 0
//   m_last     out  word was emitted by a flush
//   busy       out  packer holds or expects data, or has a word pending
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DATAWIDTH = 8,
    parameter int RATIO     = 4
) (
    input  logic                          rd_clk,
    input  logic                          rst,
    input  logic                          f_empty,
    input  logic [DATAWIDTH-1:0]          fifo_data,
    output logic                          rd_en,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATAWIDTH*RATIO-1:0]    m_data,
    output logic [RATIO-1:0]              m_keep,
    output logic                          m_last,
    output logic                          busy
);

    localparam int CW = $clog2(RATIO) + 1;   // pk_cnt counts 0..RATIO
    localparam int LW = $clog2(RATIO);       // lane index width
    localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

    // The packer state is fully implied by pk_cnt and flush_pend; it is
    // decoded rather than stored so it can never disagree with them.
    typedef enum logic [1:0] {
        ST_FILL,
        ST_FULL,
        ST_FLUSH
    } state_e;

    typedef logic [RATIO-1:0][DATAWIDTH-1:0] lanes_t;

    logic              rd_vld_q;
    logic [CW-1:0]     pk_cnt_q,     pk_cnt_d;
    lanes_t            pk_data_q,    pk_data_d;
    logic              flush_pend_q, flush_pend_d;
    lanes_t            m_data_q,     m_data_d;
    logic [RATIO-1:0]  m_keep_q,     m_keep_d;
    logic              m_last_q,     m_last_d;
    logic              m_valid_q,    m_valid_d;

    state_e            state;
    logic              xfer_want;
    logic              xfer;
    logic [CW-1:0]     cnt_after_xfer;
    logic [CW:0]       occupancy;

    // -------------------------------------------------------------------------
    // State decode and transfer condition
    // -------------------------------------------------------------------------
    always_comb begin
        if (flush_pend_q) begin
            state = ST_FLUSH;
        end else if (pk_cnt_q == FULL_CNT) begin
            state = ST_FULL;
        end else begin
            state = ST_FILL;
        end
    end

    always_comb begin
        case (state)
            ST_FULL:  xfer_want = 1'b1;
            // A flush waits for the in-flight entry to land before emitting.
            ST_FLUSH: xfer_want = (pk_cnt_q == FULL_CNT) ||
                                  (!rd_vld_q && (pk_cnt_q != '0));
            default:  xfer_want = 1'b0;
        endcase
    end

    assign xfer = xfer_want && (!m_valid_q || m_ready);

    // Credit rule: entries held plus the one in flight must stay below RATIO,
    // so a landing entry always has a free lane. Lanes freed by a transfer
    // this cycle count as free already, which makes rd_en depend on m_ready.
    assign cnt_after_xfer = xfer ? '0 : pk_cnt_q;
    assign occupancy      = {1'b0, cnt_after_xfer} + {{CW{1'b0}}, rd_vld_q};

    // Gated by rst so no pop is requested while the packer is held in reset.
    assign rd_en = rst && !f_empty && !flush_pend_q &&
                   (occupancy < (CW+1)'(RATIO));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d takes its _q value first; a path that skips an
        // assignment in combinational logic would otherwise infer a latch.
        pk_cnt_d     = pk_cnt_q;
        pk_data_d    = pk_data_q;
        flush_pend_d = flush_pend_q;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        m_valid_d    = m_valid_q;

        if (xfer) begin
            for (int i = 0; i < RATIO; i++) begin
                if (CW'(i) < pk_cnt_q) begin
                    m_data_d[i] = pk_data_q[i];
                    m_keep_d[i] = 1'b1;
                end else begin
                    m_data_d[i] = '0;
                    m_keep_d[i] = 1'b0;
                end
            end
            m_last_d  = flush_pend_q;
            m_valid_d = 1'b1;
            pk_cnt_d  = '0;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // Capture lands after any transfer, so it goes to lane 0 if the
        // packer was emptied this cycle.
        if (rd_vld_q) begin
            pk_data_d[pk_cnt_d[LW-1:0]] = fifo_data;
            pk_cnt_d                    = pk_cnt_d + 1'b1;
        end

        if (flush_pend_q) begin
            // Cleared by the flush transfer, or dropped when nothing is held
            // or in flight (no empty word is ever emitted).
            if (xfer || ((pk_cnt_q == '0) && !rd_vld_q)) begin
                flush_pend_d = 1'b0;
            end
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge rd_clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q     <= 1'b0;
            pk_cnt_q     <= '0;
            // NOTE: the lane storage is small and is reset too, so no X value
            // can ever reach m_data even before the first full word.
            pk_data_q    <= '0;
            flush_pend_q <= 1'b0;
            m_data_q     <= '0;
            m_keep_q     <= '0;
            m_last_q     <= 1'b0;
            m_valid_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values computed above, independent of statement order.
            rd_vld_q     <= rd_en;
            pk_cnt_q     <= pk_cnt_d;
            pk_data_q    <= pk_data_d;
            flush_pend_q <= flush_pend_d;
            m_data_q     <= m_data_d;
            m_keep_q     <= m_keep_d;
            m_last_q     <= m_last_d;
            m_valid_q    <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_keep  = m_keep_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;
    assign busy    = (pk_cnt_q != '0) || rd_vld_q || flush_pend_q || m_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Directed bench for fifo_rd_packer (DATAWIDTH=8, RATIO=4). A simple FIFO
// model feeds the DUT; a stream-level packing model turns the pushed entries
// and flush points into expected output words, and a compare process checks
// every accepted word, stall stability and pop legality each cycle. Each test
// also pins a few literal values computed by hand.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int DW = 8;
    localparam int R  = 4;

    logic              rd_clk = 1'b0;
    logic              rst    = 1'b0;
    logic              f_empty;
    logic [DW-1:0]     fifo_data = '0;
    logic              rd_en;
    logic              flush   = 1'b0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DW*R-1:0]   m_data;
    logic [R-1:0]      m_keep;
    logic              m_last;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    fifo_rd_packer #(.DATAWIDTH(DW), .RATIO(R)) dut (
        .rd_clk    (rd_clk),
        .rst       (rst),
        .f_empty   (f_empty),
        .fifo_data (fifo_data),
        .rd_en     (rd_en),
        .flush     (flush),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 rd_clk = ~rd_clk;
    always @(posedge rd_clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------ FIFO
    logic [DW-1:0] mem [0:255];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;

    assign f_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (rd_en && !f_empty) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // ----------------------------------------------------------------- model
    typedef struct {
        logic [DW*R-1:0] data;
        logic [R-1:0]    keep;
        logic            last;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] pend_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic emit_word(input logic last);
        word_t w;
        w.data = '0;
        w.keep = '0;
        for (int i = 0; i < pend_q.size(); i++) begin
            w.data[i*DW +: DW] = pend_q[i];
            w.keep[i]          = 1'b1;
        end
        w.last = last;
        exp_q.push_back(w);
        pend_q.delete();
    endtask

    task automatic push_entry(input logic [DW-1:0] e);
        mem[wr_ptr[7:0]] = e;
        wr_ptr = wr_ptr + 1;
        pend_q.push_back(e);
        if (pend_q.size() == R) emit_word(1'b0);
    endtask

    task automatic model_flush();
        if (pend_q.size() != 0) emit_word(1'b1);
    endtask

    // -------------------------------------------------------------- compare
    logic            prev_stall = 1'b0;
    logic [DW*R-1:0] prev_data  = '0;
    logic [R-1:0]    prev_keep  = '0;
    logic            prev_last  = 1'b0;

    always @(negedge rd_clk) begin
        word_t w;
        #1;
        if (rst) begin
            check("pop_legal", {63'd0, rd_en & f_empty}, 64'd0);
            if (prev_stall) begin
                check("stall_valid", {63'd0, m_valid}, 64'd1);
                check("stall_data", {32'd0, m_data}, {32'd0, prev_data});
                check("stall_keep", {60'd0, m_keep}, {60'd0, prev_keep});
                check("stall_last", {63'd0, m_last}, {63'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h, expected no word", m_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word_data", {32'd0, m_data}, {32'd0, w.data});
                    check("word_keep", {60'd0, m_keep}, {60'd0, w.keep});
                    check("word_last", {63'd0, m_last}, {63'd0, w.last});
                end
            end
        end
        prev_stall <= rst && m_valid && !m_ready;
        prev_data  <= m_data;
        prev_keep  <= m_keep;
        prev_last  <= m_last;
    end

    // ---------------------------------------------------------------- tests
    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},   {63'd0, rd_en},   64'd0);
        check({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_m_data"},  {32'd0, m_data},  64'd0);
        check({tag, "_m_keep"},  {60'd0, m_keep},  64'd0);
        check({tag, "_m_last"},  {63'd0, m_last},  64'd0);
        check({tag, "_busy"},    {63'd0, busy},    64'd0);
    endtask

    // Ends at negedge+1; bounded, an expired wait shows up as failed checks.
    task automatic wait_idle(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (!busy && exp_q.size() == 0) break;
            @(negedge rd_clk);
            #1;
        end
        check({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
        check({tag, "_all_words"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Waits for m_valid, returns the posedge count at which it was seen.
    task automatic wait_mvalid(input string tag, output int at_cyc);
        logic found;
        found  = 1'b0;
        at_cyc = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge rd_clk);
            #1;
            if (m_valid) begin
                found  = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        check({tag, "_mvalid_seen"}, {63'd0, found}, 64'd1);
    endtask

    initial begin
        int          c, n, m;
        logic        found;
        int unsigned start;

        // ---------------- reset state
        repeat (3) @(negedge rd_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge rd_clk);
        rst = 1'b1;

        // ---------------- basic pack and first-word latency
        @(negedge rd_clk);
        m_ready = 1'b1;
        push_entry(8'h11);
        push_entry(8'h22);
        push_entry(8'h33);
        push_entry(8'h44);
        #1;
        found = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (rd_en) begin
                found = 1'b1;
                n = cyc;
                break;
            end
            @(negedge rd_clk);
            #1;
        end
        check("t1_pop_seen", {63'd0, found}, 64'd1);
        wait_mvalid("t1", m);
        // The pop happens at posedge n+1; m_valid rises RATIO+1 edges later.
        check("t1_latency", 64'(m - n - 1), 64'd5);
        check("t1_data", {32'd0, m_data}, 64'h44332211);
        check("t1_keep", {60'd0, m_keep}, 64'hF);
        check("t1_last", {63'd0, m_last}, 64'd0);
        wait_idle("t1");

        // ---------------- backpressure
        @(negedge rd_clk);
        m_ready = 1'b0;
        start = rd_ptr;
        for (int i = 0; i < 12; i++) push_entry(8'(i));
        repeat (20) @(negedge rd_clk);
        #1;
        check("t2_pops", 64'(rd_ptr - start), 64'd8);
        check("t2_held_valid", {63'd0, m_valid}, 64'd1);
        check("t2_held_data", {32'd0, m_data}, 64'h03020100);
        @(negedge rd_clk);
        m_ready = 1'b1;
        wait_idle("t2");

        // ---------------- partial flush after FIFO runs dry
        @(negedge rd_clk);
        push_entry(8'hA1);
        push_entry(8'hB2);
        push_entry(8'hC3);
        repeat (8) @(negedge rd_clk);
        flush = 1'b1;
        model_flush();
        @(negedge rd_clk);
        flush = 1'b0;
        wait_mvalid("t3", m);
        check("t3_data", {32'd0, m_data}, 64'h00C3B2A1);
        check("t3_keep", {60'd0, m_keep}, 64'h7);
        check("t3_last", {63'd0, m_last}, 64'd1);
        wait_idle("t3");

        // ---------------- flush while the 2nd entry is in flight
        @(negedge rd_clk);
        push_entry(8'h5A);
        push_entry(8'h6B);
        c = cyc;
        @(negedge rd_clk);
        @(negedge rd_clk);
        // Pops at posedges c+1 and c+2: the 2nd entry is in flight now.
        flush = 1'b1;
        model_flush();
        @(negedge rd_clk);
        flush = 1'b0;
        @(negedge rd_clk);
        #1;
        check("t4_cycle", 64'(cyc - c), 64'd4);
        check("t4_valid", {63'd0, m_valid}, 64'd1);
        check("t4_data", {32'd0, m_data}, 64'h00006B5A);
        check("t4_keep", {60'd0, m_keep}, 64'h3);
        check("t4_last", {63'd0, m_last}, 64'd1);
        wait_idle("t4");

        // ---------------- flush with nothing held or in flight
        @(negedge rd_clk);
        flush = 1'b1;
        model_flush();
        @(negedge rd_clk);
        flush = 1'b0;
        #1;
        check("t5_busy_pend", {63'd0, busy}, 64'd1);
        check("t5_no_valid0", {63'd0, m_valid}, 64'd0);
        @(negedge rd_clk);
        #1;
        check("t5_busy_clear", {63'd0, busy}, 64'd0);
        check("t5_no_valid1", {63'd0, m_valid}, 64'd0);
        @(negedge rd_clk);
        #1;
        check("t5_no_valid2", {63'd0, m_valid}, 64'd0);

        // ---------------- reset in the middle of a word
        @(negedge rd_clk);
        push_entry(8'hE1);
        push_entry(8'hE2);
        push_entry(8'hE3);
        push_entry(8'hE4);
        c = cyc;
        repeat (3) @(negedge rd_clk);
        // Captures at posedges c+2 and c+3: two entries held.
        check("t6_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b0;
        exp_q.delete();
        pend_q.delete();
        #1;
        check_reset_outputs("t6_async");
        @(negedge rd_clk);
        wr_ptr = rd_ptr;      // the FIFO is cleared alongside the packer
        @(negedge rd_clk);
        rst = 1'b1;
        push_entry(8'h10);
        push_entry(8'h20);
        push_entry(8'h30);
        push_entry(8'h40);
        wait_mvalid("t6", m);
        check("t6_data", {32'd0, m_data}, 64'h40302010);
        check("t6_keep", {60'd0, m_keep}, 64'hF);
        check("t6_last", {63'd0, m_last}, 64'd0);
        wait_idle("t6");

        check("final_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
